uart_cmd_sequencer: RTL
=======================

Name: uart_cmd_sequencer

Overview:
Consumes bytes from the UART receiver (rx_ack/rx_data) and assembles fixed 4-byte command packets for the arm controller. Validates the header and checksum, then buffers accepted commands in a small FIFO. Commands are handed to the servo/valve scheduler through a valid/ready handshake. Sits between the UART receiver and the arm motion control logic.

Parameters:
FIFO_DEPTH, 4, command buffer entries (power of two, >=2)
ACK_GAP, 4, consecutive low cycles of rx_ack required before another byte is accepted
HDR_BYTE, 8'hAA, packet header value
TIMEOUT_CYCLES, 2_000_000, inter-byte timeout in clk cycles (20 ms at 100 MHz; used only with CMD_TIMEOUT_EN)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous active-high reset
rx_ack  in  1  byte-available strobe from UART receiver; may pulse repeatedly (toggling) for one byte
rx_data  in  8  received byte, stable while rx_ack activity lasts
cmd_valid  out  1  FIFO head holds a command
cmd_ready  in  1  downstream accepts head when high with cmd_valid
cmd_op  out  8  command opcode (packet byte 1)
cmd_arg  out  8  command argument (packet byte 2)
fifo_level  out  log2(FIFO_DEPTH)+1  entries stored
err_pulse  out  1  one-cycle pulse on any rejected packet
err_cnt  out  8  saturating count of rejected packets

Behaviour:
- Reset: all state synchronous to clk, rst active high, overrides all else. FSM -> S_HDR; FIFO empty; cmd_valid=0, cmd_op=0, cmd_arg=0, fifo_level=0, err_pulse=0, err_cnt=0; gap counter forced to "armed".
- Byte acceptance: byte_stb asserts for one cycle when rx_ack=1 and armed. Taking a byte disarms. Re-arm after rx_ack is low for ACK_GAP consecutive cycles; any rx_ack=1 while disarmed restarts the gap count. Exactly one byte_stb per received byte.
- FSM, advancing only on byte_stb:
  - S_HDR: byte==HDR_BYTE -> S_OP; other bytes discarded silently (no error).
  - S_OP: latch op -> S_ARG.
  - S_ARG: latch arg -> S_SUM.
  - S_SUM: byte==(op ^ arg ^ HDR_BYTE) -> push {op,arg} -> S_HDR.
    - Mismatch -> err_pulse, err_cnt++ -> S_HDR.
- Push rule: a push attempted when the FIFO is full (fifo_level==FIFO_DEPTH, and no pop in the same cycle) drops the packet and counts as an error. A push and a pop in the same cycle while full both succeed; level is unchanged.
- FIFO is first-word-fall-through. cmd_op/cmd_arg reflect the head whenever cmd_valid=1; otherwise they hold their last value.
- Pop occurs when cmd_valid && cmd_ready. A pushed entry is visible on cmd_valid the cycle after the push (latency 1 cycle from the checksum byte_stb). Read/write pointers wrap modulo FIFO_DEPTH.
- err_cnt saturates at 255. err_pulse lasts exactly one cycle per rejection; simultaneous sources produce a single pulse and a single increment.
- rst mid-packet discards the partial packet and all FIFO contents.

Optional Feature:
Macro CMD_TIMEOUT_EN.
- Defined: a counter runs while the FSM is in S_OP, S_ARG or S_SUM and clears on each byte_stb. On reaching TIMEOUT_CYCLES without a byte, the FSM returns to S_HDR and raises err_pulse and err_cnt++. If a timeout and a byte_stb occur in the same cycle, the byte wins.
- Undefined: no counter is built; a partial packet waits indefinitely.

Test Plan:
1. Bytes AA,12,34,8C (8C = 12^34^AA), cmd_ready=1 -> one cmd_valid cycle with cmd_op=12, cmd_arg=34; err_cnt=0.
2. rx_ack toggling 1/0 for 2604 cycles per byte, same packet as test 1 -> exactly one command; FSM advances once per byte.
3. Packet AA,12,34,00 -> err_pulse once, err_cnt=1, FIFO empty; next valid packet accepted normally.
4. cmd_ready=0, six valid packets -> fifo_level=4, err_cnt=2; then cmd_ready=1 -> first four packets pop in order.
5. Bytes 55,AA,01,02,A9 -> stray 55 ignored with no error; command op=01, arg=02.
6. CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100: send AA,01 then idle 100 cycles -> err_pulse, FSM in S_HDR; following packet AA,03,04,AD accepted.

Source files
------------

// File: rtl/uart_cmd_sequencer.sv
// UART command sequencer: assembles 4-byte {hdr, op, arg, sum} packets into a FWFT command FIFO.
// Optional inter-byte timeout is built when CMD_TIMEOUT_EN is defined.
module uart_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned ACK_GAP        = 4,
  parameter logic [7:0]  HDR_BYTE       = 8'hAA,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_ack,
  input  logic [7:0]                    rx_data,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [7:0]                    cmd_op,
  output logic [7:0]                    cmd_arg,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_pulse,
  output logic [7:0]                    err_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned GW = $clog2(ACK_GAP + 1);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (ACK_GAP < 1) ||
      (TIMEOUT_CYCLES < 2)) begin : g_param_check
    $error("uart_cmd_sequencer: illegal parameter combination");
  end

  typedef enum logic [1:0] {StHdr, StOp, StArg, StSum} state_e;

  // ---------------------------------------------------------------------------
  // Byte strobe: one strobe per byte even if rx_ack toggles while the byte is held
  // ---------------------------------------------------------------------------
  logic          armed_q, armed_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          byte_stb;

  assign byte_stb = rx_ack && armed_q;

  always_comb begin
    armed_d = armed_q;
    gap_d   = gap_q;
    if (byte_stb) begin
      armed_d = 1'b0;
      gap_d   = '0;
    end else if (!armed_q) begin
      if (rx_ack) begin
        gap_d = '0;
      end else if (gap_q == GW'(ACK_GAP - 1)) begin
        armed_d = 1'b1;
        gap_d   = '0;
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b1;
      gap_q   <= '0;
    end else begin
      armed_q <= armed_d;
      gap_q   <= gap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional inter-byte timeout
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   timeout_hit;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign timeout_hit = (state_q != StHdr) && !byte_stb && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = to_cnt_q + TW'(1);
    if ((state_q == StHdr) || byte_stb || timeout_hit) begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Packet FSM
  // ---------------------------------------------------------------------------
  logic [7:0] op_q, op_d;
  logic [7:0] arg_q, arg_d;
  logic       push_req;
  logic       sum_err;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    arg_d    = arg_q;
    push_req = 1'b0;
    sum_err  = 1'b0;
    if (byte_stb) begin
      unique case (state_q)
        StHdr: begin
          if (rx_data == HDR_BYTE) begin
            state_d = StOp;
          end
        end
        StOp: begin
          op_d    = rx_data;
          state_d = StArg;
        end
        StArg: begin
          arg_d   = rx_data;
          state_d = StSum;
        end
        StSum: begin
          if (rx_data == (op_q ^ arg_q ^ HDR_BYTE)) begin
            push_req = 1'b1;
          end else begin
            sum_err = 1'b1;
          end
          state_d = StHdr;
        end
        default: state_d = StHdr;
      endcase
    end else if (timeout_hit) begin
      state_d = StHdr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StHdr;
      op_q    <= '0;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
    end
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through command FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_op  [FIFO_DEPTH];
  logic [7:0]    mem_arg [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          full, pop, push_ok, drop;
  logic [7:0]    hold_op_q, hold_arg_q;

  assign full      = (level_q == LW'(FIFO_DEPTH));
  assign cmd_valid = (level_q != '0);
  assign pop       = cmd_valid && cmd_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push_req && (!full || pop);
  assign drop      = push_req && !push_ok;

  always_comb begin
    level_d = level_q;
    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_op[wptr_q]  <= op_q;
      mem_arg[wptr_q] <= arg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      hold_op_q  <= '0;
      hold_arg_q <= '0;
    end else begin
      level_q <= level_d;
      if (push_ok) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      if (cmd_valid) begin
        hold_op_q  <= mem_op[rptr_q];
        hold_arg_q <= mem_arg[rptr_q];
      end
    end
  end

  // Outputs keep showing the last head once the FIFO drains.
  assign cmd_op     = cmd_valid ? mem_op[rptr_q]  : hold_op_q;
  assign cmd_arg    = cmd_valid ? mem_arg[rptr_q] : hold_arg_q;
  assign fifo_level = level_q;

  // ---------------------------------------------------------------------------
  // Error reporting
  // ---------------------------------------------------------------------------
  logic       err_src;
  logic       err_pulse_q;
  logic [7:0] err_cnt_q;

  assign err_src = sum_err || drop || timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= err_src;
      if (err_src && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule
